// File: rtl/i2s_pkg.sv
// i2s_pkg: shared widths, channel indices and FSM encoding for the I2S target.
package i2s_pkg;
    localparam int WORD_BITS = 24;
    localparam int SLOT_BITS = 32;
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;
    typedef enum logic [1:0] {IDLE, ALIGN, SLOT} state_t;
    function automatic logic [1:0] ch_mask(input logic ch);
        return (ch == CH0) ? 2'b01 : 2'b10;
    endfunction
endpackage

// File: rtl/i2s_edge_sync.sv
// i2s_edge_sync: multi-flop synchronizer with one-clk rise/fall pulses from an extra delayed copy.
module i2s_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    logic              prev;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync[0] <= d;
            for (int i = 1; i < STAGES; i++) sync[i] <= sync[i-1];
            prev <= q;
        end
    end
    assign q    = sync[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/i2s_codec_target.sv
// i2s_codec_target: I2S target port, 24-bit samples in 32-bit slots, all inputs oversampled on clk.
// Receive samples on sclk rises, transmit changes on sclk falls, one-bit delay after each lrclk change.
module i2s_codec_target
    import i2s_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int MIN_OVERSAMPLE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 codec_rstn,
    input  logic                 codec_sclk,
    input  logic                 codec_lrclk,
    input  logic                 codec_sdin,
    output logic                 codec_sdout,
    output logic [1:0]           rx_vld,
    output logic [WORD_BITS-1:0] rx_data,
    output logic [1:0]           tx_ack,
    input  logic [WORD_BITS-1:0] tx_din0,
    input  logic [WORD_BITS-1:0] tx_din1,
    output logic                 frame_err
);
    logic                   sclk_q, sclk_rise, sclk_fall, lr_q, lr_rise, lr_fall;
    logic [SYNC_STAGES-1:0] rstn_s, sdin_s;
    logic                   rstn_q, sdin_q, change, ch, lr_last, pend;
    logic [4:0]             cnt;
    logic [WORD_BITS-1:0]   rx_sh, tx_sh;
    logic [32:0]            unused_sig;
    state_t                 state, state_n;

    i2s_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .rst(rst), .d(codec_sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );
    i2s_edge_sync #(.STAGES(SYNC_STAGES)) u_lrclk (
        .clk(clk), .rst(rst), .d(codec_lrclk), .q(lr_q), .rise(lr_rise), .fall(lr_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstn_s <= '0;
            sdin_s <= '0;
        end else begin
            rstn_s[0] <= codec_rstn;
            sdin_s[0] <= codec_sdin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rstn_s[i] <= rstn_s[i-1];
                sdin_s[i] <= sdin_s[i-1];
            end
        end
    end
    assign rstn_q     = rstn_s[SYNC_STAGES-1];
    assign sdin_q     = sdin_s[SYNC_STAGES-1];
    assign change     = sclk_rise && (lr_q != lr_last);
    assign unused_sig = {32'(MIN_OVERSAMPLE), sclk_q ^ lr_rise ^ lr_fall};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = !rstn_q ? IDLE : (state == IDLE) ? ALIGN : change ? SLOT : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            codec_sdout <= 1'b0;
            rx_vld      <= '0;
            tx_ack      <= '0;
            frame_err   <= 1'b0;
            rx_data     <= '0;
            cnt         <= '0;
            rx_sh       <= '0;
            tx_sh       <= '0;
            ch          <= CH0;
            lr_last     <= 1'b0;
            pend        <= 1'b0;
        end else begin
            rx_vld    <= '0;
            tx_ack    <= '0;
            frame_err <= 1'b0;
            pend      <= 1'b0;
            // tracking every clk while idle keeps a stale lr_last from faking an edge after reset
            if (sclk_rise || state == IDLE) lr_last <= lr_q;
            if (state == IDLE || !rstn_q) begin
                cnt         <= '0;
                rx_sh       <= '0;
                tx_sh       <= '0;
                codec_sdout <= 1'b0;
            end else begin
                if (change) begin
                    ch        <= lr_q;
                    cnt       <= '0;
                    tx_sh     <= (lr_q == CH1) ? tx_din1 : tx_din0;
                    tx_ack    <= ch_mask(lr_q);
                    frame_err <= (state == SLOT) && (cnt < 5'(WORD_BITS));
                end else if (sclk_rise && state == SLOT) begin
                    if (cnt < 5'(WORD_BITS)) rx_sh <= {rx_sh[WORD_BITS-2:0], sdin_q};
                    if (cnt == 5'(WORD_BITS-1)) pend <= 1'b1;
                    cnt <= (cnt == 5'(SLOT_BITS-1)) ? cnt : cnt + 5'd1;
                end
                // zero fill makes every bit past the word go out as 0
                if (sclk_fall && state == SLOT) begin
                    codec_sdout <= tx_sh[WORD_BITS-1];
                    tx_sh       <= {tx_sh[WORD_BITS-2:0], 1'b0};
                end
                if (pend) begin
                    rx_data <= rx_sh;
                    rx_vld  <= ch_mask(ch);
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_codec_target.sv
// tb_i2s_codec_target: plays I2S master streams built from half-frame lists and checks rx, tx and errors.
module tb_i2s_codec_target;
    localparam int SYNC = 2;
    localparam int MAXP = 4096;

    logic        clk = 1'b0;
    logic        rst, codec_rstn, codec_sclk, codec_lrclk, codec_sdin, codec_sdout, frame_err;
    logic [1:0]  rx_vld, tx_ack;
    logic [23:0] rx_data, tx_din0, tx_din1;
    int          checks = 0;
    int          errors = 0;

    logic        h_ch[$];
    int          h_n[$];
    logic [23:0] h_w[$];
    int          h_s[$];
    logic        lr_s[MAXP];
    logic        sd_s[MAXP];
    logic        samp[MAXP];
    int          n_per = 0;
    int          cut;

    logic        got_ch[$];
    logic [23:0] got_d[$];
    int          ack_cnt[2] = '{0, 0};
    int          ferr_cnt = 0;
    int          both_cnt = 0;

    always #5 clk = ~clk;

    i2s_codec_target #(.SYNC_STAGES(SYNC), .MIN_OVERSAMPLE(8)) dut (
        .clk(clk), .rst(rst), .codec_rstn(codec_rstn), .codec_sclk(codec_sclk),
        .codec_lrclk(codec_lrclk), .codec_sdin(codec_sdin), .codec_sdout(codec_sdout),
        .rx_vld(rx_vld), .rx_data(rx_data), .tx_ack(tx_ack), .tx_din0(tx_din0),
        .tx_din1(tx_din1), .frame_err(frame_err)
    );

    always @(negedge clk) begin
        if (rx_vld != 2'b00) begin
            got_ch.push_back(rx_vld[1]);
            got_d.push_back(rx_data);
        end
        if (tx_ack[0]) ack_cnt[0]++;
        if (tx_ack[1]) ack_cnt[1]++;
        if (frame_err) ferr_cnt++;
        if (rx_vld != 2'b00 && tx_ack != 2'b00) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        got_ch.delete();
        got_d.delete();
        ack_cnt  = '{0, 0};
        ferr_cnt = 0;
        both_cnt = 0;
    endtask

    task automatic new_scn();
        h_ch.delete();
        h_n.delete();
        h_w.delete();
        h_s.delete();
        n_per = 0;
    endtask

    task automatic add_half(input logic ch, input int n, input logic [23:0] w);
        h_ch.push_back(ch);
        h_n.push_back(n);
        h_w.push_back(w);
        h_s.push_back(n_per);
        for (int j = 0; j < n; j++) begin
            sd_s[n_per] = (j < 24) ? w[23-j] : 1'($urandom);
            lr_s[n_per] = ch;
            n_per++;
        end
    endtask

    // word select leads the data by one bit clock
    task automatic finalize();
        for (int i = 0; i < n_per - 1; i++) lr_s[i] = lr_s[i+1];
    endtask

    task automatic play(input int div, input int from, input int to);
        for (int i = from; i < to; i++) begin
            codec_sclk  = 1'b0;
            codec_lrclk = lr_s[i];
            codec_sdin  = sd_s[i];
            repeat (div / 2) @(negedge clk);
            samp[i]    = codec_sdout;
            codec_sclk = 1'b1;
            repeat (div / 2) @(negedge clk);
        end
    endtask

    task automatic restart(input logic lr);
        codec_rstn  = 1'b0;
        codec_lrclk = lr;
        repeat (SYNC + 3) @(negedge clk);
        check("idle_sdout", codec_sdout, 0);
        codec_rstn = 1'b1;
        repeat (SYNC + 3) @(negedge clk);
        clear_mon();
    endtask

    task automatic rand_words();
        tx_din0 = 24'($urandom);
        tx_din1 = 24'($urandom);
    endtask

    task automatic expect_from(input int k0, input string tag);
        logic        exp_ch[$];
        logic [23:0] exp_d[$];
        int          e_ack[2];
        int          e_ferr;
        logic [23:0] want, dec;
        logic        tail;
        e_ack  = '{0, 0};
        e_ferr = 0;
        for (int k = k0; k < h_n.size(); k++) begin
            e_ack[int'(h_ch[k])]++;
            want = h_ch[k] ? tx_din1 : tx_din0;
            if (h_n[k] >= 24) begin
                exp_ch.push_back(h_ch[k]);
                exp_d.push_back(h_w[k]);
            end else if (k < h_n.size() - 1) begin
                e_ferr++;
            end
            dec  = want;
            tail = 1'b0;
            for (int j = 0; j < h_n[k]; j++) begin
                if (j < 24) dec[23-j] = samp[h_s[k]+j];
                else tail = tail | samp[h_s[k]+j];
            end
            check($sformatf("%s_tx%0d", tag, k), dec, want);
            if (h_n[k] > 24) check($sformatf("%s_tail%0d", tag, k), tail, 0);
        end
        check({tag, "_rx_count"}, got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size(); i++) begin
            check($sformatf("%s_rx_data%0d", tag, i), (i < got_d.size()) ? got_d[i] : 24'hx, exp_d[i]);
            check($sformatf("%s_rx_ch%0d", tag, i), (i < got_ch.size()) ? got_ch[i] : 1'bx, exp_ch[i]);
        end
        check({tag, "_ack0"}, ack_cnt[0], e_ack[0]);
        check({tag, "_ack1"}, ack_cnt[1], e_ack[1]);
        check({tag, "_frame_err"}, ferr_cnt, e_ferr);
        check({tag, "_rx_ack_overlap"}, both_cnt, 0);
    endtask

    initial begin
        rst         = 1'b1;
        codec_rstn  = 1'b0;
        codec_sclk  = 1'b0;
        codec_lrclk = 1'b0;
        codec_sdin  = 1'b0;
        tx_din0     = 24'hC00001;
        tx_din1     = 24'h800000;
        clear_mon();
        repeat (3) @(negedge clk);
        check("rst_sdout", codec_sdout, 0);
        check("rst_rx_vld", rx_vld, 0);
        check("rst_tx_ack", tx_ack, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_rx_data", rx_data, 0);
        rst        = 1'b0;
        codec_rstn = 1'b1;
        repeat (SYNC + 3) @(negedge clk);

        new_scn();
        add_half(1'b0, 32, 24'hA5A5A5);
        add_half(1'b1, 32, 24'h123456);
        add_half(1'b0, 32, 24'hA5A5A5);
        add_half(1'b1, 32, 24'h123456);
        finalize();
        play(8, 0, h_s[1]);
        check("align_no_rx", got_d.size(), 0);
        play(8, h_s[1], n_per);
        repeat (8) @(negedge clk);
        expect_from(1, "basic");

        restart(1'b0);
        rand_words();
        new_scn();
        add_half(1'b0, 32, 24'($urandom));
        add_half(1'b1, 32, 24'($urandom));
        add_half(1'b0, 32, 24'($urandom));
        add_half(1'b1, 10, 24'($urandom));
        add_half(1'b0, 32, 24'($urandom));
        add_half(1'b1, 32, 24'($urandom));
        finalize();
        play(8, 0, n_per);
        repeat (8) @(negedge clk);
        expect_from(1, "short");

        restart(1'b0);
        rand_words();
        new_scn();
        add_half(1'b0, 32, 24'($urandom));
        add_half(1'b1, 40, 24'($urandom));
        add_half(1'b0, 32, 24'($urandom));
        add_half(1'b1, 32, 24'($urandom));
        finalize();
        play(8, 0, n_per);
        repeat (8) @(negedge clk);
        expect_from(1, "long");

        for (int m = 0; m < 2; m++) begin
            restart(1'b0);
            tx_din0 = 24'($urandom);
            tx_din1 = 24'hFFFFFF;
            new_scn();
            add_half(1'b0, 32, 24'($urandom));
            add_half(1'b1, 36, 24'($urandom));
            add_half(1'b0, 32, 24'($urandom));
            add_half(1'b1, 32, 24'($urandom));
            finalize();
            cut = h_s[1] + 12;
            play(8, 0, cut);
            check(m == 0 ? "rstn_pre_sdout" : "rst_pre_sdout", codec_sdout, 1);
            if (m == 0) begin
                codec_rstn = 1'b0;
                repeat (SYNC + 1) @(negedge clk);
                check("rstn_low_sdout", codec_sdout, 0);
                repeat (4) @(negedge clk);
                codec_rstn = 1'b1;
            end else begin
                rst = 1'b1;
                #1;
                check("rst_mid_sdout", codec_sdout, 0);
                check("rst_mid_rx_data", rx_data, 0);
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
            check(m == 0 ? "rstn_cut_no_rx" : "rst_cut_no_rx", got_d.size(), 0);
            check(m == 0 ? "rstn_cut_no_err" : "rst_cut_no_err", ferr_cnt, 0);
            repeat (SYNC + 3) @(negedge clk);
            clear_mon();
            play(8, cut, n_per);
            repeat (8) @(negedge clk);
            expect_from(2, m == 0 ? "rstn_resume" : "rst_resume");
        end

        for (int d = 8; d <= 16; d += 8) begin
            restart(1'b0);
            rand_words();
            new_scn();
            for (int f = 0; f < 32; f++) begin
                add_half(1'b0, 32, 24'($urandom));
                add_half(1'b1, 32, 24'($urandom));
            end
            finalize();
            play(d, 0, n_per);
            repeat (2 * d) @(negedge clk);
            expect_from(1, $sformatf("sweep%0d", d));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
